// File: rtl/ctrl_pkg.sv
// Shared opcode constants, control-field encodings and the per-stage control bundles
// carried down the RV32I pipeline.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                              IMM_J = 3'b011, IMM_U = 3'b100} imm_src_e;
    typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01,
                              RES_PC4 = 2'b10, RES_IMM = 2'b11} result_src_e;
    typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_BR = 2'b01,
                              ALUOP_FUNCT = 2'b10} alu_op_e;

    typedef struct packed {
        logic       reg_write;
        logic       alu_src;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
        logic       jalr_sel;
        logic       alu_a_src;
        logic       valid;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic [1:0] result_src;
        logic       valid;
        logic       illegal;
    } mem_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       valid;
        logic       illegal;
    } wb_ctrl_t;

    localparam ctrl_t     CTRL_BUBBLE = '0;
    localparam mem_ctrl_t MEM_BUBBLE  = '0;
    localparam wb_ctrl_t  WB_BUBBLE   = '0;

endpackage

// File: rtl/rv32_main_decoder.sv
// Combinational RV32I main decoder: opcode -> control bundle and immediate select.
// Zero latency; no flow control. Illegal opcodes give all-zero controls with illegal=valid.
module rv32_main_decoder
    import ctrl_pkg::*;
#(
    parameter bit EXT_OPS = 1'b1
) (
    input  logic [6:0] op,
    input  logic       valid,
    output logic [2:0] imm_src,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        imm_src = IMM_I;
        if (valid) begin
            ctrl.valid = 1'b1;
            case (op)
                OP_LOAD: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.alu_src    = 1'b1;
                    ctrl.result_src = RES_MEM;
                end
                OP_STORE: begin
                    imm_src        = IMM_S;
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                end
                OP_R: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                OP_BRANCH: begin
                    imm_src     = IMM_B;
                    ctrl.branch = 1'b1;
                    ctrl.alu_op = ALUOP_BR;
                end
                OP_IALU: begin
                    if (EXT_OPS) begin
                        ctrl.reg_write = 1'b1;
                        ctrl.alu_src   = 1'b1;
                        ctrl.alu_op    = ALUOP_FUNCT;
                    end else begin
                        ctrl.illegal = 1'b1;
                    end
                end
                OP_JAL: begin
                    if (EXT_OPS) begin
                        imm_src         = IMM_J;
                        ctrl.reg_write  = 1'b1;
                        ctrl.result_src = RES_PC4;
                        ctrl.jump       = 1'b1;
                    end else begin
                        ctrl.illegal = 1'b1;
                    end
                end
                OP_JALR: begin
                    if (EXT_OPS) begin
                        ctrl.reg_write  = 1'b1;
                        ctrl.alu_src    = 1'b1;
                        ctrl.result_src = RES_PC4;
                        ctrl.jump       = 1'b1;
                        ctrl.jalr_sel   = 1'b1;
                    end else begin
                        ctrl.illegal = 1'b1;
                    end
                end
                OP_LUI: begin
                    if (EXT_OPS) begin
                        imm_src         = IMM_U;
                        ctrl.reg_write  = 1'b1;
                        ctrl.result_src = RES_IMM;
                    end else begin
                        ctrl.illegal = 1'b1;
                    end
                end
                OP_AUIPC: begin
                    if (EXT_OPS) begin
                        imm_src        = IMM_U;
                        ctrl.reg_write = 1'b1;
                        ctrl.alu_src   = 1'b1;
                        ctrl.alu_a_src = 1'b1;
                    end else begin
                        ctrl.illegal = 1'b1;
                    end
                end
                default: ctrl.illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/control_pipeline.sv
// RV32I control path: decode in D, then ID/EX, EX/MEM, MEM/WB control registers.
// D->E 1 edge, W after 3 edges; only ID/EX can be flushed, no stalls; retire counter on W.
module control_pipeline
    import ctrl_pkg::*;
#(
    parameter bit EXT_OPS = 1'b1,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Op_D,
    input  logic             valid_D,
    input  logic             FlushE,
    output logic [2:0]       ImmSrc_D,
    output logic             RegWrite_E,
    output logic             MemWrite_E,
    output logic             Branch_E,
    output logic             Jump_E,
    output logic             JalrSel_E,
    output logic             ALUSrc_E,
    output logic             ALUASrc_E,
    output logic [1:0]       ALUOp_E,
    output logic [1:0]       ResultSrc_E,
    output logic             RegWrite_M,
    output logic             MemWrite_M,
    output logic [1:0]       ResultSrc_M,
    output logic             RegWrite_W,
    output logic [1:0]       ResultSrc_W,
    output logic             valid_W,
    output logic             illegal_W,
    output logic             illegal_seen,
    output logic [CNT_W-1:0] retired_cnt
);

    ctrl_t            dec_ctrl;
    ctrl_t            ex_d, ex_q;
    mem_ctrl_t        mem_d, mem_q;
    wb_ctrl_t         wb_d, wb_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             seen_d, seen_q;

    rv32_main_decoder #(.EXT_OPS(EXT_OPS)) u_dec (
        .op      (Op_D),
        .valid   (valid_D),
        .imm_src (ImmSrc_D),
        .ctrl    (dec_ctrl)
    );

    always_comb begin
        // A flushed slot is a plain bubble, so an illegal opcode there is never flagged.
        ex_d = FlushE ? CTRL_BUBBLE : dec_ctrl;

        mem_d.reg_write  = ex_q.reg_write;
        mem_d.mem_write  = ex_q.mem_write;
        mem_d.result_src = ex_q.result_src;
        mem_d.valid      = ex_q.valid;
        mem_d.illegal    = ex_q.illegal;

        wb_d.reg_write   = mem_q.reg_write;
        wb_d.result_src  = mem_q.result_src;
        wb_d.valid       = mem_q.valid;
        wb_d.illegal     = mem_q.illegal;

        cnt_d = cnt_q;
        if (wb_q.valid && !wb_q.illegal) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        seen_d = seen_q | (wb_q.valid & wb_q.illegal);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q   <= CTRL_BUBBLE;
            mem_q  <= MEM_BUBBLE;
            wb_q   <= WB_BUBBLE;
            cnt_q  <= '0;
            seen_q <= 1'b0;
        end else begin
            ex_q   <= ex_d;
            mem_q  <= mem_d;
            wb_q   <= wb_d;
            cnt_q  <= cnt_d;
            seen_q <= seen_d;
        end
    end

    assign RegWrite_E   = ex_q.reg_write;
    assign MemWrite_E   = ex_q.mem_write;
    assign Branch_E     = ex_q.branch;
    assign Jump_E       = ex_q.jump;
    assign JalrSel_E    = ex_q.jalr_sel;
    assign ALUSrc_E     = ex_q.alu_src;
    assign ALUASrc_E    = ex_q.alu_a_src;
    assign ALUOp_E      = ex_q.alu_op;
    assign ResultSrc_E  = ex_q.result_src;
    assign RegWrite_M   = mem_q.reg_write;
    assign MemWrite_M   = mem_q.mem_write;
    assign ResultSrc_M  = mem_q.result_src;
    assign RegWrite_W   = wb_q.reg_write;
    assign ResultSrc_W  = wb_q.result_src;
    assign valid_W      = wb_q.valid;
    assign illegal_W    = wb_q.illegal;
    assign illegal_seen = seen_q;
    assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Two instances (full decode / 32-bit counter, base decode / 4-bit counter) driven in
// lockstep and checked every cycle against a table-driven history model.
module tb_control_pipeline;

    // Control word layout: {rw, imm[2:0], alusrc, mw, rs[1:0], br, aluop[1:0], jump, jalr, alua}
    typedef struct packed {
        logic [13:0] c;
        logic        v;
        logic        il;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] Op_D = '0;
    logic       valid_D = 1'b0;
    logic       FlushE = 1'b0;

    logic [2:0]  imm1, imm0;
    logic        rwe1, mwe1, bre1, jpe1, jre1, ase1, aae1, rwe0, mwe0, bre0, jpe0, jre0, ase0, aae0;
    logic [1:0]  aoe1, rse1, aoe0, rse0;
    logic        rwm1, mwm1, rwm0, mwm0;
    logic [1:0]  rsm1, rsm0;
    logic        rww1, vw1, ilw1, rww0, vw0, ilw0;
    logic [1:0]  rsw1, rsw0;
    logic        seen1, seen0;
    logic [31:0] cnt1;
    logic [3:0]  cnt0;

    int ncmp = 0;
    int nbad = 0;

    ent_t        h1[$];
    ent_t        h0[$];
    logic [31:0] m_cnt1;
    logic [3:0]  m_cnt0;
    logic        m_seen1, m_seen0;

    always #5 clk = ~clk;

    control_pipeline #(.EXT_OPS(1'b1), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .Op_D(Op_D), .valid_D(valid_D), .FlushE(FlushE),
        .ImmSrc_D(imm1), .RegWrite_E(rwe1), .MemWrite_E(mwe1), .Branch_E(bre1),
        .Jump_E(jpe1), .JalrSel_E(jre1), .ALUSrc_E(ase1), .ALUASrc_E(aae1),
        .ALUOp_E(aoe1), .ResultSrc_E(rse1), .RegWrite_M(rwm1), .MemWrite_M(mwm1),
        .ResultSrc_M(rsm1), .RegWrite_W(rww1), .ResultSrc_W(rsw1), .valid_W(vw1),
        .illegal_W(ilw1), .illegal_seen(seen1), .retired_cnt(cnt1)
    );

    control_pipeline #(.EXT_OPS(1'b0), .CNT_W(4)) dut0 (
        .clk(clk), .rst(rst), .Op_D(Op_D), .valid_D(valid_D), .FlushE(FlushE),
        .ImmSrc_D(imm0), .RegWrite_E(rwe0), .MemWrite_E(mwe0), .Branch_E(bre0),
        .Jump_E(jpe0), .JalrSel_E(jre0), .ALUSrc_E(ase0), .ALUASrc_E(aae0),
        .ALUOp_E(aoe0), .ResultSrc_E(rse0), .RegWrite_M(rwm0), .MemWrite_M(mwm0),
        .ResultSrc_M(rsm0), .RegWrite_W(rww0), .ResultSrc_W(rsw0), .valid_W(vw0),
        .illegal_W(ilw0), .illegal_seen(seen0), .retired_cnt(cnt0)
    );

    function automatic ent_t model_dec(input logic [6:0] op, input logic v, input bit ext);
        ent_t e;
        e = '0;
        if (v) begin
            e.v = 1'b1;
            case (op)
                7'b0000011: e.c = 14'b1_000_1_0_01_0_00_0_0_0;
                7'b0100011: e.c = 14'b0_001_1_1_00_0_00_0_0_0;
                7'b0110011: e.c = 14'b1_000_0_0_00_0_10_0_0_0;
                7'b1100011: e.c = 14'b0_010_0_0_00_1_01_0_0_0;
                7'b0010011: if (ext) e.c = 14'b1_000_1_0_00_0_10_0_0_0; else e.il = 1'b1;
                7'b1101111: if (ext) e.c = 14'b1_011_0_0_10_0_00_1_0_0; else e.il = 1'b1;
                7'b1100111: if (ext) e.c = 14'b1_000_1_0_10_0_00_1_1_0; else e.il = 1'b1;
                7'b0110111: if (ext) e.c = 14'b1_100_0_0_11_0_00_0_0_0; else e.il = 1'b1;
                7'b0010111: if (ext) e.c = 14'b1_100_1_0_00_0_00_0_0_1; else e.il = 1'b1;
                default:    e.il = 1'b1;
            endcase
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] e_view(input logic [13:0] c);
        return {c[13], c[9], c[8], c[7:6], c[5], c[4:3], c[2], c[1], c[0]};
    endfunction

    task automatic model_reset();
        h1 = '{ent_t'(0), ent_t'(0), ent_t'(0)};
        h0 = '{ent_t'(0), ent_t'(0), ent_t'(0)};
        m_cnt1 = '0; m_cnt0 = '0; m_seen1 = 1'b0; m_seen0 = 1'b0;
    endtask

    task automatic check_all();
        chk("E_ext", {21'd0, rwe1, ase1, mwe1, rse1, bre1, aoe1, jpe1, jre1, aae1}, {21'd0, e_view(h1[0].c)});
        chk("M_ext", {28'd0, rwm1, mwm1, rsm1}, {28'd0, h1[1].c[13], h1[1].c[8], h1[1].c[7:6]});
        chk("W_ext", {27'd0, rww1, rsw1, vw1, ilw1}, {27'd0, h1[2].c[13], h1[2].c[7:6], h1[2].v, h1[2].il});
        chk("cnt_ext", cnt1, m_cnt1);
        chk("seen_ext", {31'd0, seen1}, {31'd0, m_seen1});
        chk("E_base", {21'd0, rwe0, ase0, mwe0, rse0, bre0, aoe0, jpe0, jre0, aae0}, {21'd0, e_view(h0[0].c)});
        chk("M_base", {28'd0, rwm0, mwm0, rsm0}, {28'd0, h0[1].c[13], h0[1].c[8], h0[1].c[7:6]});
        chk("W_base", {27'd0, rww0, rsw0, vw0, ilw0}, {27'd0, h0[2].c[13], h0[2].c[7:6], h0[2].v, h0[2].il});
        chk("cnt_base", {28'd0, cnt0}, {28'd0, m_cnt0});
        chk("seen_base", {31'd0, seen0}, {31'd0, m_seen0});
    endtask

    // Called at a negedge: drive D, check the combinational immediate select, take one edge.
    task automatic step(input logic [6:0] op, input logic v, input logic fl);
        ent_t d1, d0;
        Op_D = op; valid_D = v; FlushE = fl;
        d1 = model_dec(op, v, 1'b1);
        d0 = model_dec(op, v, 1'b0);
        #1;
        chk("ImmSrc_D_ext", {29'd0, imm1}, {29'd0, d1.c[12:10]});
        chk("ImmSrc_D_base", {29'd0, imm0}, {29'd0, d0.c[12:10]});
        @(posedge clk);
        if (h1[2].v && !h1[2].il) m_cnt1 = m_cnt1 + 1;
        if (h1[2].v && h1[2].il) m_seen1 = 1'b1;
        if (h0[2].v && !h0[2].il) m_cnt0 = m_cnt0 + 1;
        if (h0[2].v && h0[2].il) m_seen0 = 1'b1;
        h1.push_front(fl ? ent_t'(0) : d1); void'(h1.pop_back());
        h0.push_front(fl ? ent_t'(0) : d0); void'(h0.pop_back());
        @(negedge clk);
        check_all();
    endtask

    task automatic hard_reset();
        #1 rst = 1'b0;
        model_reset();
        #1 check_all();
        #1 rst = 1'b1;
    endtask

    logic [6:0] legal_ops[9];

    initial begin
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b1;

        // Load through the pipe, then drain so it retires.
        step(7'b0000011, 1'b1, 1'b0);
        chk("lw_E_resultsrc", {30'd0, rse1}, 32'd1);
        repeat (3) step(7'b0000000, 1'b0, 1'b0);
        chk("lw_retired", cnt1, 32'd1);

        // All legal opcodes, then an undefined one.
        for (int i = 0; i < 9; i++) step(legal_ops[i], 1'b1, 1'b0);
        step(7'b1111111, 1'b1, 1'b0);
        repeat (3) step(7'b0000000, 1'b0, 1'b0);
        chk("sweep_seen", {31'd0, seen1}, 32'd1);
        chk("sweep_cnt", cnt1, 32'd10);

        // JAL on the base-only decoder is illegal.
        step(7'b1101111, 1'b1, 1'b0);
        chk("jal_base_jump", {31'd0, jpe0}, 32'd0);
        repeat (3) step(7'b0000000, 1'b0, 1'b0);

        // Flushed store, and flushed illegal opcode.
        step(7'b0100011, 1'b1, 1'b1);
        step(7'b1111110, 1'b1, 1'b1);
        repeat (3) step(7'b0000000, 1'b0, 1'b0);

        // Async reset mid-stream.
        hard_reset();
        for (int i = 0; i < 3; i++) step(legal_ops[i], 1'b1, 1'b0);
        hard_reset();
        chk("arst_cnt", cnt1, 32'd0);
        chk("arst_RegWrite_E", {31'd0, rwe1}, 32'd0);
        for (int i = 3; i < 5; i++) step(legal_ops[i], 1'b1, 1'b0);
        repeat (3) step(7'b0000000, 1'b0, 1'b0);
        chk("post_arst_cnt", cnt1, 32'd2);

        // 17 loads wrap the 4-bit counter to 1.
        hard_reset();
        repeat (17) step(7'b0000011, 1'b1, 1'b0);
        repeat (3) step(7'b0000000, 1'b0, 1'b0);
        chk("wrap_cnt4", {28'd0, cnt0}, 32'd1);
        chk("wrap_cnt32", cnt1, 32'd17);

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic [6:0] op;
            logic v, fl;
            if ($urandom_range(0, 3) == 0) op = 7'($urandom);
            else op = legal_ops[$urandom_range(0, 8)];
            v  = ($urandom_range(0, 5) != 0);
            fl = ($urandom_range(0, 6) == 0);
            step(op, v, fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule

// File: doc/control_pipeline.md
# control_pipeline

Control path for the 5-stage RV32I core: decodes the opcode in D and carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers. It extends the minimal lw/sw/R/beq decode to I-type ALU, JAL, JALR, LUI and AUIPC, gated by a parameter. It adds per-stage valid bits, flush-to-bubble, an illegal-opcode flag and a retired-instruction counter. It sits between the fetch/decode datapath and the hazard unit.

## Interface
- EXT_OPS, 1, 1 = decode I-ALU/JAL/JALR/LUI/AUIPC; 0 = only lw/sw/R/beq, all other opcodes illegal
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-low reset; one clock domain only
- Op_D  in  7  instruction[6:0] in D
- valid_D  in  1  D holds a real instruction
- FlushE  in  1  load bubble into ID/EX on next edge (hazard unit)
- ImmSrc_D  out  3  immediate select for extender in D (combinational)
- RegWrite_E, MemWrite_E, Branch_E, Jump_E, JalrSel_E, ALUSrc_E, ALUASrc_E  out  1 each  EX controls
- ALUOp_E  out  2  to ALU decoder
- ResultSrc_E  out  2  also used by hazard unit for load-use detection
- RegWrite_M, MemWrite_M  out  1 each;  ResultSrc_M  out  2
- RegWrite_W  out  1;  ResultSrc_W  out  2;  valid_W, illegal_W  out  1 each
- illegal_seen  out  1  sticky, set when an illegal instruction reaches W
- retired_cnt  out  CNT_W  count of legal instructions that left W

## Operation
- Encodings: ImmSrc 000 I, 001 S, 010 B, 011 J, 100 U. ResultSrc 00 ALU, 01 mem, 10 PC+4, 11 ImmExt. ALUOp 00 add, 01 branch compare, 10 funct decode.
- Decode fields are RegWrite/ImmSrc/ALUSrc/MemWrite/ResultSrc/Branch/ALUOp/Jump/JalrSel/ALUASrc. Any field not listed is 0.
  - 0000011 lw: 1/000/1/0/01/0/00
  - 0100011 sw: 0/001/1/1/00/0/00
  - 0110011 R: 1/000/0/0/00/0/10
  - 1100011 branch: 0/010/0/0/00/1/01
  - 0010011 I-ALU: 1/000/1/0/00/0/10
  - 1101111 JAL: 1/011/0/0/10/0/00, Jump=1
  - 1100111 JALR: 1/000/1/0/10/0/00, Jump=1, JalrSel=1
  - 0110111 LUI: 1/100/0/0/11/0/00
  - 0010111 AUIPC: 1/100/1/0/00/0/00, ALUASrc=1
- Any other opcode, or an EXT_OPS=0 excluded opcode, is illegal. All controls are 0 and illegal=valid_D.
- valid_D=0 produces a bubble: all controls 0, valid 0, illegal 0.
- ID/EX: FlushE=1 loads a bubble; otherwise it loads the decode of Op_D. FlushE wins over everything.
- EX/MEM and MEM/WB always advance; they have no stall input.
- retired_cnt increments by 1 on each edge where valid_W=1 and illegal_W=0. It wraps modulo 2^CNT_W.
- illegal_seen is set on an edge where valid_W & illegal_W; it clears only on reset.

## Timing
- ImmSrc_D is combinational from Op_D with zero latency.
- An instruction in D at edge n appears in E after edge n, in M after n+1, and in W after n+2.
- retired_cnt reflects a W instruction one edge after it is in W.
- Reset (rst=0) asynchronously clears every registered output, all valid bits, illegal_seen and retired_cnt to 0. Outputs stay 0 while rst=0.
- A reset asserted mid-flight discards all in-flight instructions; none are counted.
- Simultaneous FlushE and illegal Op_D: a bubble enters E, and the illegal instruction is neither flagged nor counted.

## Structure
- Shared package ctrl_pkg holds the opcode constants, ImmSrc/ResultSrc/ALUOp encodings and a packed control-bundle struct with its bubble constant.
- One combinational sub-module, rv32_main_decoder (Op, valid, EXT_OPS → bundle, illegal). The top instantiates it plus three pipeline registers and the counter.

## Test plan
- Reset, then valid_D=1 with Op_D=0000011: ImmSrc_D=000 immediately; next edge RegWrite_E=1, ALUSrc_E=1, ResultSrc_E=01; two edges later ResultSrc_W=01 and valid_W=1; retired_cnt=1 one edge after that.
- Sweep all 9 legal opcodes with EXT_OPS=1: each E-stage bundle matches the encoding list; Op_D=1111111 gives all-zero controls, illegal_W=1 after 3 edges, illegal_seen=1, and retired_cnt is unchanged.
- EXT_OPS=0 with Op_D=1101111: Jump_E=0, ImmSrc_D=000, and the instruction is flagged illegal at W.
- Op_D=0100011 with FlushE=1 on the same edge: MemWrite_E=0 and MemWrite_M=0 on subsequent cycles; retired_cnt is not incremented.
- Stream of 5 legal instructions, with rst pulsed low asynchronously between edges mid-stream: all outputs go 0 immediately; after release, retired_cnt counts only post-reset instructions.
- CNT_W=4 with 17 legal instructions: retired_cnt=1 after wrap.
